// File: rtl/id_stage.sv
// id_stage: registered RV decode stage with valid/ready handshakes, a RAW register scoreboard,
// registered JAL/JALR redirect, flush and illegal-instruction flagging. Define ID_MEXT_EN to decode the M extension.
package id_stage_pkg;
  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
endpackage

module id_stage
  import id_stage_pkg::*;
#(
  parameter int XLEN = 64,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  input  logic [XLEN-1:0] rs1val_i,
  input  logic [XLEN-1:0] rs2val_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] operand1_o,
  output logic [XLEN-1:0] operand2_o,
  output logic [4:0]      rd_o,
  output logic            rf_wen_o,
  output logic [4:0]      aluop_o,
  output logic [XLEN-1:0] pc_o,
  output logic            illegal_o,
  output logic            branch_o,
  output logic [XLEN-1:0] new_pc_o,
  input  logic            flush_i,
  input  logic            wb_valid_i,
  input  logic [4:0]      wb_rd_i,
  output logic            exit_o
);
  localparam bit RV64 = (XLEN == 64);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2, rd_f;
  logic [XLEN-1:0] imm_i, imm_u, imm_j, shamt_imm, shamt_reg;
  logic shamt_hi_ok;

  assign opcode = inst_i[6:0];
  assign rd_f   = inst_i[11:7];
  assign funct3 = inst_i[14:12];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];
  assign funct7 = inst_i[31:25];
  assign rs1_o  = rs1;
  assign rs2_o  = rs2;

  assign imm_i     = XLEN'(signed'(inst_i[31:20]));
  assign imm_u     = XLEN'(signed'({inst_i[31:12], 12'b0}));
  assign imm_j     = XLEN'(signed'({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
  assign shamt_imm = XLEN'(inst_i[20 +: SHW]);
  assign shamt_reg = XLEN'(rs2val_i[SHW-1:0]);
  // On RV32 the immediate shift amount has only five bits, so inst[25] must be clear.
  assign shamt_hi_ok = RV64 || !inst_i[25];

  logic [XLEN-1:0] dec_op1, dec_op2, dec_target;
  alu_op_e         dec_alu;
  logic            dec_wr, dec_wen, dec_ill, use_rs1, use_rs2, is_jump, is_ebreak;
  logic [4:0]      dec_rd;

  // NOTE: every signal gets a default at the top of the block, so no path can infer a latch.
  always_comb begin
    dec_op1    = '0;
    dec_op2    = '0;
    dec_target = '0;
    dec_alu    = ALU_ADD;
    dec_wr     = 1'b0;
    dec_ill    = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    is_jump    = 1'b0;
    is_ebreak  = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        use_rs1 = 1'b1;
        dec_wr  = 1'b1;
        dec_op1 = rs1val_i;
        dec_op2 = imm_i;
        case (funct3)
          3'b000: dec_alu = ALU_ADD;
          3'b010: dec_alu = ALU_SLT;
          3'b011: dec_alu = ALU_SLTU;
          3'b100: dec_alu = ALU_XOR;
          3'b110: dec_alu = ALU_OR;
          3'b111: dec_alu = ALU_AND;
          3'b001: begin
            dec_alu = ALU_SLL;
            dec_op2 = shamt_imm;
            dec_ill = !(inst_i[31:26] == 6'b000000 && shamt_hi_ok);
          end
          default: begin
            dec_op2 = shamt_imm;
            if (inst_i[31:26] == 6'b000000)      dec_alu = ALU_SRL;
            else if (inst_i[31:26] == 6'b010000) dec_alu = ALU_SRA;
            else                                 dec_ill = 1'b1;
            if (!shamt_hi_ok) dec_ill = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_wr  = 1'b1;
        dec_op1 = rs1val_i;
        dec_op2 = rs2val_i;
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'b000: dec_alu = ALU_ADD;
              3'b001: begin dec_alu = ALU_SLL; dec_op2 = shamt_reg; end
              3'b010: dec_alu = ALU_SLT;
              3'b011: dec_alu = ALU_SLTU;
              3'b100: dec_alu = ALU_XOR;
              3'b101: begin dec_alu = ALU_SRL; dec_op2 = shamt_reg; end
              3'b110: dec_alu = ALU_OR;
              default: dec_alu = ALU_AND;
            endcase
          end
          7'b0100000: begin
            if (funct3 == 3'b000)      dec_alu = ALU_SUB;
            else if (funct3 == 3'b101) begin dec_alu = ALU_SRA; dec_op2 = shamt_reg; end
            else                       dec_ill = 1'b1;
          end
`ifdef ID_MEXT_EN
          7'b0000001: begin
            case (funct3)
              3'b000: dec_alu = ALU_MUL;
              3'b001: dec_alu = ALU_MULH;
              3'b010: dec_alu = ALU_MULHSU;
              3'b011: dec_alu = ALU_MULHU;
              3'b100: dec_alu = ALU_DIV;
              3'b101: dec_alu = ALU_DIVU;
              3'b110: dec_alu = ALU_REM;
              default: dec_alu = ALU_REMU;
            endcase
          end
`endif
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec_wr  = 1'b1;
        dec_op1 = imm_u;
      end
      OPC_AUIPC: begin
        dec_wr  = 1'b1;
        dec_op1 = pc_i;
        dec_op2 = imm_u;
      end
      OPC_JAL: begin
        dec_wr     = 1'b1;
        is_jump    = 1'b1;
        dec_op1    = pc_i;
        dec_op2    = XLEN'(4);
        dec_target = pc_i + imm_j;
      end
      OPC_JALR: begin
        use_rs1    = 1'b1;
        dec_wr     = 1'b1;
        dec_op1    = pc_i;
        dec_op2    = XLEN'(4);
        dec_target = (rs1val_i + imm_i) & ~XLEN'(1);
        if (funct3 == 3'b000) is_jump = 1'b1;
        else                  dec_ill = 1'b1;
      end
      OPC_SYSTEM: begin
        if (inst_i == INST_EBREAK) is_ebreak = 1'b1;
        else                       dec_ill   = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_wr  = 1'b0;
      dec_alu = ALU_ADD;
    end
  end

  // Writes to x0 are dropped here so rd_o/rf_wen_o never advertise x0 downstream.
  assign dec_wen = dec_wr && (rd_f != 5'd0);
  assign dec_rd  = dec_wen ? rd_f : 5'd0;

  logic [31:0] busy, busy_next;
  logic        pend_wr, hit_rs1, hit_rs2, hit_rd, hazard, issue, out_fire;

  assign pend_wr  = out_valid && rf_wen_o;
  assign hit_rs1  = use_rs1 && (rs1 != 5'd0) && (busy[rs1] || (pend_wr && rd_o == rs1));
  assign hit_rs2  = use_rs2 && (rs2 != 5'd0) && (busy[rs2] || (pend_wr && rd_o == rs2));
  assign hit_rd   = dec_wen && (busy[rd_f] || (pend_wr && rd_o == rd_f));
  assign hazard   = hit_rs1 || hit_rs2 || hit_rd;
  assign in_ready = (!out_valid || out_ready) && !hazard && !branch_o && !flush_i;
  assign issue    = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Set is applied after clear so a same-cycle set of the same register wins.
  always_comb begin
    busy_next = busy;
    if (wb_valid_i && wb_rd_i != 5'd0) busy_next[wb_rd_i] = 1'b0;
    if (out_fire && rf_wen_o && rd_o != 5'd0) busy_next[rd_o] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      operand1_o <= '0;
      operand2_o <= '0;
      rd_o       <= '0;
      rf_wen_o   <= 1'b0;
      aluop_o    <= ALU_ADD;
      pc_o       <= '0;
      illegal_o  <= 1'b0;
      branch_o   <= 1'b0;
      new_pc_o   <= '0;
      exit_o     <= 1'b0;
      busy       <= '0;
    end else begin
      busy     <= busy_next;
      branch_o <= issue && is_jump;
      if (flush_i)        out_valid <= 1'b0;
      else if (issue)     out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (issue) begin
        operand1_o <= dec_op1;
        operand2_o <= dec_op2;
        rd_o       <= dec_rd;
        rf_wen_o   <= dec_wen;
        aluop_o    <= dec_alu;
        pc_o       <= pc_i;
        illegal_o  <= dec_ill;
        if (is_jump)   new_pc_o <= dec_target;
        if (is_ebreak) exit_o   <= 1'b1;
      end
    end
  end
endmodule

// File: doc/id_stage.md
# id_stage

Pipelined, parametrised RV decode stage between ifetch and ex. It replaces the purely combinational decoder with a registered output stage and valid/ready handshakes on both sides. It adds a 32-entry register scoreboard for RAW stalls, registered JAL/JALR redirect, flush support and illegal-instruction flagging. XLEN is selectable (32 or 64); M-extension decode is compile-time optional.

## Interface
- XLEN, 64, datapath width; legal values 32 and 64.
- SHW, $clog2(XLEN), shift-amount width (derived; not overridden).

- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  ifetch offers inst_i/pc_i.
- in_ready  out  1  id accepts this cycle.
- inst_i  in  32  instruction word.
- pc_i  in  XLEN  instruction pc.
- rs1_o, rs2_o  out  5  combinational regfile read addresses = inst_i[19:15], inst_i[24:20].
- rs1val_i, rs2val_i  in  XLEN  regfile read data, same cycle.
- out_valid  out  1  decoded instruction present for ex.
- out_ready  in  1  ex consumes this cycle.
- operand1_o, operand2_o  out  XLEN  ALU operands.
- rd_o  out  5  destination; 0 when rf_wen_o=0.
- rf_wen_o  out  1  register write enable.
- aluop_o  out  5  ALU op, encodings from define.v.
- pc_o  out  XLEN  pc of the decoded instruction.
- illegal_o  out  1  unsupported encoding; rf_wen_o forced 0.
- branch_o  out  1  one-cycle redirect pulse to ifetch.
- new_pc_o  out  XLEN  redirect target, valid while branch_o=1.
- flush_i  in  1  kill the output register (younger-than-ex squash).
- wb_valid_i  in  1  writeback retiring.
- wb_rd_i  in  5  writeback destination.
- exit_o  out  1  sticky: set once EBREAK issues.

## Operation
- Decode matches the existing RV64I subset: OP-IMM, OP, JAL, JALR, AUIPC, LUI, EBREAK. Operand rules: I/R ops use rs1/rs2 values or SEXT(immI); JAL/JALR use pc and 4; AUIPC uses pc and SEXT(immU)<<12; LUI uses SEXT(immU)<<12 and 0.
- Shifts: operand2 = shamt[SHW-1:0] (imm or rs2 value, zero-extended). With XLEN=32, slli/srli/srai with inst[25]=1 are illegal.
- Undefined opcode/funct3/funct7 combinations set illegal_o=1, rf_wen_o=0, aluop_o=ALU_ADD. The instruction still issues.
- Scoreboard: 32-bit busy mask; bit 0 is never set.
  - Set on output handshake (out_valid & out_ready & rf_wen_o & rd_o≠0).
  - Clear on wb_valid_i with wb_rd_i≠0.
  - Same rd set and cleared in one cycle: set wins.
- Hazard: stall when a source or rd of inst_i matches a busy bit or the output register's rd_o (out_valid & rf_wen_o). Registers only count as sources if the format uses them. x0 never matches.
- in_ready = (~out_valid | out_ready) & ~hazard & ~branch_o & ~flush_i.
- Issue (in_valid & in_ready): the output register loads the decode result, and out_valid=1.
- Redirect: a JAL/JALR issue sets branch_o=1 next cycle with new_pc_o = pc+SEXT(immJ) or (rs1val+SEXT(immI)) & ~1. Ifetch discards wrong-path fetches.
- exit_o: set when EBREAK issues; cleared only by reset.

## Timing
- Reset (rst_n=0 at posedge): out_valid, branch_o, exit_o, illegal_o, rf_wen_o = 0; rd_o = 0; operands, pc_o, new_pc_o = 0; busy mask = 0.
- Decode latency: 1 cycle from issue to out_valid.
- Output stays stable while out_valid & ~out_ready.
- flush_i: out_valid and branch_o clear next cycle; no issue that cycle. The busy mask is unaffected. Flush and a simultaneous out handshake: the handshake completes (ex accepted it) and the busy bit is set.
- Back-to-back: with out_ready=1 and no hazard, one instruction per cycle.
- A clear takes effect the cycle after wb_valid_i, so the regfile write lands before the dependent read.

## Configuration
- ID_MEXT_EN:
  - Defined: OP with funct7=0000001 decodes mul/mulh/mulhsu/mulhu/div/divu/rem/remu to ALU_MUL..ALU_REMU from define.v, with operands rs1/rs2.
  - Undefined: these encodings are illegal (illegal_o=1, rf_wen_o=0).

## Test plan
- Reset: hold rst_n=0 two cycles with in_valid=1 -> every output 0, no issue; release -> addi x1,x0,5 gives out_valid=1 next cycle, operand2_o=5, rd_o=1.
- RAW stall: issue addi x1; next add x2,x1,x1 with out_ready=1, then wb_valid_i/wb_rd_i=1 three cycles later -> in_ready=0 until the cycle after writeback; add issues then with rs1val.
- Backpressure/flush: out_ready=0 for 4 cycles -> output stable, in_ready=0; assert flush_i -> out_valid=0 next cycle, busy mask unchanged.
- Redirect: jalr x1,0x7(x5) with rs1val=0x1000 -> branch_o one cycle, new_pc_o=0x1006, operand1_o=pc, operand2_o=4, in_ready=0 that cycle.
- XLEN=32: slli x3,x3,32 (inst[25]=1) -> illegal_o=1, rf_wen_o=0; slli by 31 -> operand2_o=31.
- ID_MEXT_EN: mul x4,x5,x6 -> aluop_o=ALU_MUL when defined; illegal_o=1 when undefined. EBREAK -> exit_o=1 and stays 1.
